// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read checker and write generator.
package fifo_pkg;

    // Read-side burst FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } rd_state_t;

    localparam int DEFAULT_DATA_LEN = 8;
    localparam int DEFAULT_CNT_W    = 16;

    // First word of the incrementing pattern; the write generator starts here too.
    localparam int PATTERN_SEED = 0;

    // Bits needed to hold values 0..n inclusive (never less than 1).
    function automatic int cnt_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_checker.sv
// Checks popped FIFO words against the incrementing pattern and keeps the
// last word, read/error counters and the sticky mismatch flag.
module pattern_checker
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = DEFAULT_DATA_LEN,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic [DATA_LEN-1:0] data_out,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                mismatch
);

    // rd_data belongs to the pop issued one cycle earlier; vld_q marks that cycle.
    logic                vld_q;
    logic [DATA_LEN-1:0] exp_q;
    logic                word_ok;

    assign word_ok = (rd_data == exp_q);

    // Delay the pop request to line up with the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= rd_en;
        end
    end

    // Compare, count and resync on each returned word; reset drops a pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q    <= DATA_LEN'(PATTERN_SEED);
            data_out <= '0;
            rd_cnt   <= '0;
            err_cnt  <= '0;
            mismatch <= 1'b0;
        end else if (vld_q) begin
            data_out <= rd_data;
            rd_cnt   <= rd_cnt + 1'b1;
            // Next expected always follows the word just seen, so one bad word
            // costs one error plus at most one more for the word after it.
            exp_q    <= rd_data + 1'b1;
            if (!word_ok) begin
                mismatch <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side consumer of the async FIFO: pops in bursts separated by idle
// gaps so the FIFO fills, and checks every popped word.
//
// Handshake: the FIFO offers a word whenever empty=0 (its "valid"); rd_en is
// our "ready". A pop happens exactly in a cycle where rd_en=1, which implies
// empty=0, so no pop is ever issued against an empty FIFO. Data for that pop
// arrives on rd_data in the following cycle.
module fifo_rd_checker
    import fifo_pkg::*;
#(
    parameter int DATA_LEN  = DEFAULT_DATA_LEN,
    parameter int BURST_LEN = 4,
    parameter int GAP_LEN   = 6,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                empty,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic                rd_en,
    output logic [DATA_LEN-1:0] data_out,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                mismatch,
    output rd_state_t           dbg_state
);

    localparam int BW = cnt_bits(BURST_LEN);
    localparam int GW = cnt_bits(GAP_LEN);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_LEN - 1);

    rd_state_t     state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [GW-1:0] gap_q, gap_d;

    assign rd_en     = (state_q == READ) & enable & ~empty;
    assign dbg_state = state_q;

    // State and burst/gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            burst_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

    // Next state: bursts of BURST_LEN accepted pops, then GAP_LEN idle cycles.
    // The burst counter is cleared on the pop that completes the burst, so it
    // never holds BURST_LEN itself.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        if (!enable) begin
            state_d = IDLE;
            burst_d = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = READ;
                end
                READ: begin
                    if (rd_en) begin
                        if (burst_q == BURST_LAST) begin
                            state_d = GAP;
                            burst_d = '0;
                            gap_d   = '0;
                        end else begin
                            burst_d = burst_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = READ;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    burst_d = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

    pattern_checker #(
        .DATA_LEN (DATA_LEN),
        .CNT_W    (CNT_W)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .data_out (data_out),
        .rd_cnt   (rd_cnt),
        .err_cnt  (err_cnt),
        .mismatch (mismatch)
    );

endmodule
